// File: rtl/interleaver_block_feeder.sv
// interleaver_block_feeder: collects one K-bit block of bytes into the interleaver shift register,
// then holds ready_out for exactly K cycles while the interleaver emits.
module interleaver_block_feeder #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       k_size_6144,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] databyte_out,
  output logic       shift_en,
  output logic       ready_out,
  output logic       k_latched,
  output logic       busy,
  output logic       block_done
);
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t      r_state;
  logic [9:0]  r_byte_cnt;
  logic [12:0] r_bit_cnt;
  logic        w_accept;
  logic [9:0]  w_byte_nxt;
  logic [9:0]  w_n_bytes;
  logic [12:0] w_k_last;
  assign in_ready   = r_state != EMIT;
  assign busy       = r_state != IDLE;
  assign w_accept   = in_valid & in_ready;
  assign w_byte_nxt = r_byte_cnt + 10'd1;
  assign w_n_bytes  = k_latched ? 10'(K_LARGE / 8) : 10'(K_SMALL / 8);
  assign w_k_last   = k_latched ? 13'(K_LARGE - 1) : 13'(K_SMALL - 1);
  // The first EMIT cycle only raises ready_out, leaving one idle cycle after the last shift.
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      r_state      <= IDLE;
      r_byte_cnt   <= '0;
      r_bit_cnt    <= '0;
      databyte_out <= '0;
      shift_en     <= 1'b0;
      ready_out    <= 1'b0;
      k_latched    <= 1'b0;
      block_done   <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      block_done <= 1'b0;
      if (abort) begin
        r_state    <= IDLE;
        r_byte_cnt <= '0;
        r_bit_cnt  <= '0;
        ready_out  <= 1'b0;
      end else
        case (r_state)
          IDLE:
            if (w_accept) begin
              k_latched    <= k_size_6144;
              r_byte_cnt   <= 10'd1;
              databyte_out <= in_data;
              shift_en     <= 1'b1;
              r_state      <= FILL;
            end
          FILL:
            if (w_accept) begin
              r_byte_cnt   <= w_byte_nxt;
              databyte_out <= in_data;
              shift_en     <= 1'b1;
              if (w_byte_nxt == w_n_bytes) begin
                r_state   <= EMIT;
                r_bit_cnt <= '0;
              end
            end
          EMIT:
            if (!ready_out)
              ready_out <= 1'b1;
            else if (r_bit_cnt == w_k_last) begin
              ready_out  <= 1'b0;
              block_done <= 1'b1;
              r_state    <= IDLE;
              r_byte_cnt <= '0;
              r_bit_cnt  <= '0;
            end else
              r_bit_cnt <= r_bit_cnt + 13'd1;
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_interleaver_block_feeder.sv
// tb_interleaver_block_feeder: randomized bench against a timestamp-based model of the block feeder.
module tb_interleaver_block_feeder;
  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       k_size_6144 = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] databyte_out;
  logic       shift_en;
  logic       ready_out;
  logic       k_latched;
  logic       busy;
  logic       block_done;
  localparam int FAR = -100000;
  int n_vec = 0;
  int n_err = 0;
  int cyc, t_last, m_k, fill, m_blk;
  logic m_kl, m_shift;
  logic [7:0] m_data;
  int n_sh, n_ro, n_bd;
  always #5 clock = ~clock;
  interleaver_block_feeder dut (
    .clock(clock), .rst(rst), .k_size_6144(k_size_6144), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .databyte_out(databyte_out), .shift_en(shift_en), .ready_out(ready_out),
    .k_latched(k_latched), .busy(busy), .block_done(block_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // A block whose last byte was accepted at cycle t_last stalls the source over [t_last+1, t_last+1+K].
  function automatic bit in_emit(input int c);
    return c >= t_last + 1 && c <= t_last + 1 + m_k;
  endfunction
  task automatic model_reset;
    cyc = 0;
    t_last = FAR;
    m_k = 1056;
    fill = 0;
    m_kl = 1'b0;
    m_shift = 1'b0;
    m_data = 8'h00;
  endtask
  task automatic check_outputs;
    chk("in_ready", in_ready, !in_emit(cyc));
    chk("busy", busy, fill > 0 || in_emit(cyc));
    chk("shift_en", shift_en, m_shift);
    chk("databyte_out", databyte_out, m_data);
    chk("ready_out", ready_out, cyc >= t_last + 2 && cyc <= t_last + 1 + m_k);
    chk("block_done", block_done, cyc == t_last + 2 + m_k);
    chk("k_latched", k_latched, m_kl);
    n_sh += int'(shift_en);
    n_ro += int'(ready_out);
    n_bd += int'(block_done);
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic k, input logic ab);
    bit acc;
    in_valid = v;
    in_data = d;
    k_size_6144 = k;
    abort = ab;
    acc = v && !in_emit(cyc) && !ab;
    m_shift = acc;
    if (acc) begin
      m_data = d;
      if (fill == 0) m_kl = k;
      fill++;
      if (fill == (m_kl ? 768 : 132)) begin
        t_last = cyc;
        m_k = m_kl ? 6144 : 1056;
        fill = 0;
        m_blk++;
      end
    end
    if (ab) begin
      fill = 0;
      t_last = FAR;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_outputs();
  endtask
  task automatic run_blocks(input int nblk, input int duty, input logic ksel, input int toggle_after, input bit seq);
    int guard = 0;
    n_sh = 0;
    n_ro = 0;
    n_bd = 0;
    m_blk = 0;
    while (!(m_blk >= nblk && cyc >= t_last + 2 + m_k)) begin
      if (guard++ > 30000) begin
        chk("timeout", guard, 0);
        break;
      end
      step($urandom_range(99) < duty, seq ? 8'(fill) : 8'($urandom),
           (toggle_after >= 0 && fill >= toggle_after) ? 1'b1 : ksel, 1'b0);
    end
  endtask
  task automatic do_reset;
    in_valid = 1'b0;
    abort = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    rst = 1'b1;
  endtask
  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clock);
    rst = 1'b1;
    run_blocks(1, 100, 1'b0, -1, 1'b1);
    chk("t1_shift_cnt", n_sh, 132);
    chk("t1_ready_cnt", n_ro, 1056);
    chk("t1_done_cnt", n_bd, 1);
    run_blocks(1, 30, 1'b1, -1, 1'b0);
    chk("t2_shift_cnt", n_sh, 768);
    chk("t2_ready_cnt", n_ro, 6144);
    chk("t2_done_cnt", n_bd, 1);
    run_blocks(1, 100, 1'b0, 5, 1'b0);
    chk("t3_klatched", k_latched, 0);
    chk("t3_shift_cnt", n_sh, 132);
    chk("t3_ready_cnt", n_ro, 1056);
    repeat (50) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    run_blocks(1, 100, 1'b0, -1, 1'b0);
    chk("t4_shift_cnt", n_sh, 132);
    chk("t4_ready_cnt", n_ro, 1056);
    repeat (132) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    while (cyc < t_last + 2 + 300) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    chk("t5_ready_cleared", ready_out, 0);
    run_blocks(1, 100, 1'b0, -1, 1'b0);
    chk("t5_shift_cnt", n_sh, 132);
    chk("t5_ready_cnt", n_ro, 1056);
    repeat (20) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    chk("t6_no_shift", shift_en, 0);
    chk("t6_idle", busy, 0);
    run_blocks(1, 100, 1'b0, -1, 1'b0);
    chk("t6_shift_cnt", n_sh, 132);
    chk("t6_ready_cnt", n_ro, 1056);
    run_blocks(2, 100, 1'b0, -1, 1'b0);
    chk("t7_shift_cnt", n_sh, 264);
    chk("t7_ready_cnt", n_ro, 2112);
    chk("t7_done_cnt", n_bd, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
